ipfilter_lookup_sched: RTL and testbench

- Shares one masked-address comparator between the TX and RX IPv4 filter paths.
- Arbitrates lookup requests round-robin and scans the requester's rule table sequentially.
- Returns a drop/pass verdict per request and keeps saturating drop counters.
- Sits between the ipfilter register block (rule tables, counter readback) and the TX/RX packet-parse stages.

---
 rtl/ipfilter_lookup_sched.sv | 176 +++++++++++++++++
 tb/tb_ipfilter_lookup_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipfilter_lookup_sched.sv
// Shared masked-address lookup engine for the TX/RX IPv4 filter paths, round-robin arbitrated.
// Build option: IPFILTER_LOOKUP_EARLY_EXIT_EN ends the scan at the first hit; otherwise scan time is constant.
module ipfilter_lookup_sched #(
  parameter int unsigned NUM_ENTRIES = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tx_vld          [NUM_ENTRIES],
  input  logic [31:0]                    tx_ipv4_addr    [NUM_ENTRIES],
  input  logic [31:0]                    tx_ipv4_netmask [NUM_ENTRIES],
  input  logic                           rx_vld          [NUM_ENTRIES],
  input  logic [31:0]                    rx_ipv4_addr    [NUM_ENTRIES],
  input  logic [31:0]                    rx_ipv4_netmask [NUM_ENTRIES],
  input  logic                           tx_req_valid,
  output logic                           tx_req_ready,
  input  logic [31:0]                    tx_req_addr,
  input  logic                           rx_req_valid,
  output logic                           rx_req_ready,
  input  logic [31:0]                    rx_req_addr,
  output logic                           tx_rsp_valid,
  input  logic                           tx_rsp_ready,
  output logic                           tx_rsp_drop,
  output logic [$clog2(NUM_ENTRIES)-1:0] tx_rsp_idx,
  output logic                           rx_rsp_valid,
  input  logic                           rx_rsp_ready,
  output logic                           rx_rsp_drop,
  output logic [$clog2(NUM_ENTRIES)-1:0] rx_rsp_idx,
  output logic [31:0]                    tx_drop_cnt,
  output logic [31:0]                    rx_drop_cnt,
  output logic                           busy
);

  localparam int unsigned   IW       = $clog2(NUM_ENTRIES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENTRIES - 1);
  localparam logic          DIR_TX   = 1'b0;
  localparam logic          DIR_RX   = 1'b1;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t        state;
  logic          dir;
  logic          last_dir;
  logic [31:0]   addr;
  logic [IW-1:0] idx;
`ifndef IPFILTER_LOOKUP_EARLY_EXIT_EN
  logic          found;
  logic [IW-1:0] hit_idx;
`endif

  logic          grant_tx_c, grant_rx_c;
  logic          ent_vld_c;
  logic [31:0]   ent_addr_c, ent_mask_c;
  logic          hit_c, last_c;
  logic          fin_c, fin_drop_c;
  logic [IW-1:0] fin_idx_c;

  // Round-robin grant: on a tie the side not served last wins.
  assign grant_tx_c   = tx_req_valid && (!rx_req_valid || (last_dir == DIR_RX));
  assign grant_rx_c   = rx_req_valid && !grant_tx_c;
  assign tx_req_ready = rst_n && (state == IDLE) && grant_tx_c;
  assign rx_req_ready = rst_n && (state == IDLE) && grant_rx_c;
  assign busy         = (state != IDLE);

  // Live read of the current entry of the selected table.
  always_comb begin
    ent_vld_c  = tx_vld[idx];
    ent_addr_c = tx_ipv4_addr[idx];
    ent_mask_c = tx_ipv4_netmask[idx];
    if (dir == DIR_RX) begin
      ent_vld_c  = rx_vld[idx];
      ent_addr_c = rx_ipv4_addr[idx];
      ent_mask_c = rx_ipv4_netmask[idx];
    end
  end

  assign hit_c  = ent_vld_c && ((addr & ent_mask_c) == (ent_addr_c & ent_mask_c));
  assign last_c = (idx == LAST_IDX);

  // Scan termination and verdict for this cycle.
  always_comb begin
    fin_c      = 1'b0;
    fin_drop_c = 1'b0;
    fin_idx_c  = '0;
`ifdef IPFILTER_LOOKUP_EARLY_EXIT_EN
    fin_c      = hit_c || last_c;
    fin_drop_c = hit_c;
    fin_idx_c  = hit_c ? idx : '0;
`else
    fin_c      = last_c;
    fin_drop_c = found || hit_c;
    fin_idx_c  = found ? hit_idx : (hit_c ? idx : '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dir          <= DIR_TX;
      last_dir     <= DIR_RX;
      addr         <= '0;
      idx          <= '0;
`ifndef IPFILTER_LOOKUP_EARLY_EXIT_EN
      found        <= 1'b0;
      hit_idx      <= '0;
`endif
      tx_rsp_valid <= 1'b0;
      tx_rsp_drop  <= 1'b0;
      tx_rsp_idx   <= '0;
      rx_rsp_valid <= 1'b0;
      rx_rsp_drop  <= 1'b0;
      rx_rsp_idx   <= '0;
      tx_drop_cnt  <= '0;
      rx_drop_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_req_ready || rx_req_ready) begin
            addr     <= rx_req_ready ? rx_req_addr : tx_req_addr;
            dir      <= rx_req_ready;
            last_dir <= rx_req_ready;
            idx      <= '0;
`ifndef IPFILTER_LOOKUP_EARLY_EXIT_EN
            found    <= 1'b0;
            hit_idx  <= '0;
`endif
            state    <= SCAN;
          end
        end
        SCAN: begin
`ifndef IPFILTER_LOOKUP_EARLY_EXIT_EN
          if (hit_c && !found) begin
            found   <= 1'b1;
            hit_idx <= idx;
          end
`endif
          if (fin_c) begin
            state <= RESP;
            if (dir == DIR_RX) begin
              rx_rsp_valid <= 1'b1;
              rx_rsp_drop  <= fin_drop_c;
              rx_rsp_idx   <= fin_idx_c;
            end else begin
              tx_rsp_valid <= 1'b1;
              tx_rsp_drop  <= fin_drop_c;
              tx_rsp_idx   <= fin_idx_c;
            end
          end else begin
            idx <= idx + IW'(1);
          end
        end
        RESP: begin
          // Counter is taken on the verdict handshake and saturates at all-ones.
          if (dir == DIR_RX) begin
            if (rx_rsp_ready) begin
              state        <= IDLE;
              rx_rsp_valid <= 1'b0;
              rx_rsp_drop  <= 1'b0;
              rx_rsp_idx   <= '0;
              if (rx_rsp_drop && (rx_drop_cnt != '1)) rx_drop_cnt <= rx_drop_cnt + 32'd1;
            end
          end else begin
            if (tx_rsp_ready) begin
              state        <= IDLE;
              tx_rsp_valid <= 1'b0;
              tx_rsp_drop  <= 1'b0;
              tx_rsp_idx   <= '0;
              if (tx_rsp_drop && (tx_drop_cnt != '1)) tx_drop_cnt <= tx_drop_cnt + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipfilter_lookup_sched.sv
// Scoreboard bench for ipfilter_lookup_sched: grants and verdicts are queued by stimulus, checked by monitor.
module tb_ipfilter_lookup_sched;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_vld [N];
  logic [31:0] tx_ipv4_addr [N];
  logic [31:0] tx_ipv4_netmask [N];
  logic        rx_vld [N];
  logic [31:0] rx_ipv4_addr [N];
  logic [31:0] rx_ipv4_netmask [N];
  logic        tx_req_valid, tx_req_ready, rx_req_valid, rx_req_ready;
  logic [31:0] tx_req_addr, rx_req_addr;
  logic        tx_rsp_valid, tx_rsp_ready, tx_rsp_drop;
  logic        rx_rsp_valid, rx_rsp_ready, rx_rsp_drop;
  logic [3:0]  tx_rsp_idx, rx_rsp_idx;
  logic [31:0] tx_drop_cnt, rx_drop_cnt;
  logic        busy;

  ipfilter_lookup_sched #(.NUM_ENTRIES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_vld(tx_vld), .tx_ipv4_addr(tx_ipv4_addr), .tx_ipv4_netmask(tx_ipv4_netmask),
    .rx_vld(rx_vld), .rx_ipv4_addr(rx_ipv4_addr), .rx_ipv4_netmask(rx_ipv4_netmask),
    .tx_req_valid(tx_req_valid), .tx_req_ready(tx_req_ready), .tx_req_addr(tx_req_addr),
    .rx_req_valid(rx_req_valid), .rx_req_ready(rx_req_ready), .rx_req_addr(rx_req_addr),
    .tx_rsp_valid(tx_rsp_valid), .tx_rsp_ready(tx_rsp_ready), .tx_rsp_drop(tx_rsp_drop),
    .tx_rsp_idx(tx_rsp_idx),
    .rx_rsp_valid(rx_rsp_valid), .rx_rsp_ready(rx_rsp_ready), .rx_rsp_drop(rx_rsp_drop),
    .rx_rsp_idx(rx_rsp_idx),
    .tx_drop_cnt(tx_drop_cnt), .rx_drop_cnt(rx_drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dir;
    logic       drop;
    logic [3:0] idx;
    int         lat;
  } rsp_t;

  rsp_t rsp_q [$];
  logic grant_q [$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   hs_cnt = 0;
  int   hs_cyc = 0;
  int   rsp_cnt = 0;
  int   first_cyc = 0;
  int   nexp = 0;
  logic rsp_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: grant order, ready exclusivity and verdict scoreboard.
  logic       m_dir, m_g;
  logic [5:0] m_oth;
  rsp_t       m_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_seen = 1'b0;
    end else begin
      if (tx_req_valid && rx_req_valid) begin
        checks++;
        if (tx_req_ready && rx_req_ready) begin
          errors++;
          $display("FAIL both_ready: got tx=1 rx=1 expected one-hot (cycle %0d)", cyc);
        end
      end
      if ((tx_req_valid && tx_req_ready) || (rx_req_valid && rx_req_ready)) begin
        hs_cnt++;
        hs_cyc = cyc;
        checks++;
        m_dir = rx_req_valid && rx_req_ready;
        if (grant_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: got dir %0d expected none (cycle %0d)", m_dir, cyc);
        end else begin
          m_g = grant_q.pop_front();
          if (m_g !== m_dir) begin
            errors++;
            $display("FAIL grant_dir: got %0d expected %0d (cycle %0d)", m_dir, m_g, cyc);
          end
        end
      end
      if (tx_rsp_valid || rx_rsp_valid) begin
        if (!rsp_seen) begin
          rsp_seen  = 1'b1;
          first_cyc = cyc;
        end
        if ((tx_rsp_valid && tx_rsp_ready) || (rx_rsp_valid && rx_rsp_ready)) begin
          rsp_seen = 1'b0;
          rsp_cnt++;
          checks++;
          m_dir = rx_rsp_valid;
          m_oth = m_dir ? {tx_rsp_valid, tx_rsp_drop, tx_rsp_idx} : {rx_rsp_valid, rx_rsp_drop, rx_rsp_idx};
          if (rsp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got dir %0d expected no verdict (cycle %0d)", m_dir, cyc);
          end else begin
            m_e = rsp_q.pop_front();
            if (m_dir !== m_e.dir || (m_dir ? rx_rsp_drop : tx_rsp_drop) !== m_e.drop ||
                (m_dir ? rx_rsp_idx : tx_rsp_idx) !== m_e.idx || (first_cyc - hs_cyc) != m_e.lat ||
                m_oth !== 6'd0) begin
              errors++;
              $display("FAIL rsp: got dir=%0d drop=%0d idx=%0d lat=%0d other=%h expected dir=%0d drop=%0d idx=%0d lat=%0d other=0",
                       m_dir, m_dir ? rx_rsp_drop : tx_rsp_drop, m_dir ? rx_rsp_idx : tx_rsp_idx,
                       first_cyc - hs_cyc, m_oth, m_e.dir, m_e.drop, m_e.idx, m_e.lat);
            end
          end
        end
      end
    end
  end

  task automatic expect_rsp(input logic d, input logic drop, input int k);
    rsp_t e;
    e.dir  = d;
    e.drop = drop;
    e.idx  = drop ? 4'(k) : 4'd0;
`ifdef IPFILTER_LOOKUP_EARLY_EXIT_EN
    e.lat  = drop ? 2 + k : 1 + N;
`else
    e.lat  = 1 + N;
`endif
    rsp_q.push_back(e);
    nexp++;
  endtask

  task automatic issue(input logic d, input logic [31:0] a);
    int base;
    base = hs_cnt;
    grant_q.push_back(d);
    @(posedge clk); #1;
    if (d) begin rx_req_valid = 1'b1; rx_req_addr = a; end
    else   begin tx_req_valid = 1'b1; tx_req_addr = a; end
    for (int i = 0; i < 200 && hs_cnt == base; i++) @(posedge clk);
    if (hs_cnt == base) chk("req_timeout", 32'(hs_cnt), 32'(base + 1));
    #1;
    if (d) rx_req_valid = 1'b0;
    else   tx_req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 400 && rsp_cnt < nexp; i++) @(negedge clk);
    if (rsp_cnt < nexp) chk("rsp_timeout", 32'(rsp_cnt), 32'(nexp));
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    for (int i = 0; i < N; i++) begin
      tx_vld[i] = 1'b0; tx_ipv4_addr[i] = '0; tx_ipv4_netmask[i] = '0;
      rx_vld[i] = 1'b0; rx_ipv4_addr[i] = '0; rx_ipv4_netmask[i] = '0;
    end
    tx_vld[3] = 1'b1; tx_ipv4_addr[3] = 32'h0A000000; tx_ipv4_netmask[3] = 32'hFF000000;
    tx_vld[7] = 1'b1; tx_ipv4_addr[7] = 32'hC0A80000; tx_ipv4_netmask[7] = 32'hFFFF0000;
    rx_ipv4_addr[5] = 32'hC0A80000; rx_ipv4_netmask[5] = 32'hFFFF0000;
    tx_req_addr = '0; rx_req_addr = '0; rx_req_valid = 1'b0;
    tx_rsp_ready = 1'b1; rx_rsp_ready = 1'b1;

    // Reset with a pending request: nothing may be accepted.
    rst_n = 1'b0; tx_req_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", 32'(tx_req_ready), 0);
    chk("rst_rx_ready", 32'(rx_req_ready), 0);
    chk("rst_rsp_valid", {30'd0, tx_rsp_valid, rx_rsp_valid}, 0);
    chk("rst_rsp_drop_idx", {22'd0, tx_rsp_drop, rx_rsp_drop, tx_rsp_idx, rx_rsp_idx}, 0);
    chk("rst_tx_cnt", tx_drop_cnt, 0);
    chk("rst_rx_cnt", rx_drop_cnt, 0);
    chk("rst_busy", 32'(busy), 0);
    tx_req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // TX hit on entry 3.
    expect_rsp(1'b0, 1'b1, 3);
    issue(1'b0, 32'h0A010203);
    wait_rsp();
    chk("tx_cnt_1", tx_drop_cnt, 1);

    // RX miss: empty RX table, disabled RX rule and matching TX rule must not count.
    expect_rsp(1'b1, 1'b0, 0);
    issue(1'b1, 32'hC0A80001);
    wait_rsp();
    chk("rx_cnt_0", rx_drop_cnt, 0);

    // TX miss: disabled all-zero-mask entries must not match.
    expect_rsp(1'b0, 1'b0, 0);
    issue(1'b0, 32'h0B000001);
    wait_rsp();
    chk("tx_cnt_miss", tx_drop_cnt, 1);

    // Two overlapping RX rules: lowest index wins.
    rx_vld[9]  = 1'b1; rx_ipv4_addr[9]  = 32'hAC100000; rx_ipv4_netmask[9]  = 32'hFFF00000;
    rx_vld[12] = 1'b1; rx_ipv4_addr[12] = 32'hAC100500; rx_ipv4_netmask[12] = 32'hFFFFFF00;
    expect_rsp(1'b1, 1'b1, 9);
    issue(1'b1, 32'hAC100509);
    wait_rsp();
    chk("rx_cnt_1", rx_drop_cnt, 1);

    // Both sides requesting continuously: TX, RX, TX, RX.
    for (int i = 0; i < 4; i++) begin
      grant_q.push_back(i[0]);
      if (i[0]) expect_rsp(1'b1, 1'b1, 9);
      else      expect_rsp(1'b0, 1'b1, 3);
    end
    base = hs_cnt;
    @(posedge clk); #1;
    tx_req_valid = 1'b1; tx_req_addr = 32'h0A010203;
    rx_req_valid = 1'b1; rx_req_addr = 32'hAC100509;
    for (int i = 0; i < 400 && hs_cnt < base + 4; i++) @(posedge clk);
    chk("rr_grants", 32'(hs_cnt - base), 4);
    #1 tx_req_valid = 1'b0; rx_req_valid = 1'b0;
    wait_rsp();
    chk("rr_tx_cnt", tx_drop_cnt, 3);
    chk("rr_rx_cnt", rx_drop_cnt, 3);

    // Back-pressure on the verdict with a competing RX request.
    tx_rsp_ready = 1'b0;
    expect_rsp(1'b0, 1'b1, 3);
    issue(1'b0, 32'h0A010203);
    base = hs_cnt;
    grant_q.push_back(1'b1);
    expect_rsp(1'b1, 1'b0, 0);
    rx_req_valid = 1'b1; rx_req_addr = 32'hC0A80001;
    for (int i = 0; i < 100 && !tx_rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid_drop_idx", {26'd0, tx_rsp_valid, tx_rsp_drop, tx_rsp_idx}, {26'd0, 2'b11, 4'd3});
      chk("hold_busy_rx_ready", {30'd0, busy, rx_req_ready}, 32'd2);
      chk("hold_tx_cnt", tx_drop_cnt, 3);
    end
    @(posedge clk); #1 tx_rsp_ready = 1'b1;
    for (int i = 0; i < 100 && hs_cnt == base; i++) @(posedge clk);
    #1 rx_req_valid = 1'b0;
    wait_rsp();
    chk("hold_tx_cnt_after", tx_drop_cnt, 4);
    chk("hold_rx_cnt_after", rx_drop_cnt, 3);

    // Saturation from a preloaded counter.
    @(posedge clk); #1 force dut.tx_drop_cnt = 32'hFFFFFFFE;
    @(posedge clk); #1 release dut.tx_drop_cnt;
    @(negedge clk);
    chk("sat_preload", tx_drop_cnt, 32'hFFFFFFFE);
    for (int i = 0; i < 3; i++) begin
      expect_rsp(1'b0, 1'b1, 3);
      issue(1'b0, 32'h0A010203);
      wait_rsp();
      chk("sat_cnt", tx_drop_cnt, 32'hFFFFFFFF);
    end

    // Reset during SCAN aborts the lookup silently.
    issue(1'b0, 32'h0A010203);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rsp_valid", {30'd0, tx_rsp_valid, rx_rsp_valid}, 0);
    chk("abort_tx_cnt", tx_drop_cnt, 0);
    chk("abort_rx_cnt", rx_drop_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_cnt), 32'(nexp));
    expect_rsp(1'b0, 1'b1, 3);
    issue(1'b0, 32'h0A010203);
    wait_rsp();
    chk("post_abort_tx_cnt", tx_drop_cnt, 1);

    chk("rsp_q_empty", 32'(rsp_q.size()), 0);
    chk("grant_q_empty", 32'(grant_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
